// File: rtl/edge_cacheline_unpacker_pkg.sv
// Shared cache-unit constants and types for the edge cacheline unpacker.
// Holds the cacheline/edge geometry and the unpacker FSM state encoding.
// Contents: CACHELINE_SIZE, EDGE_SIZE, CACHELINE_EDGE_NUM, CACHELINE_EDGE_IDX_BITS, unpacker_state_e.
package GLOBALS_CU_PKG;

  localparam int CACHELINE_SIZE          = 128;                          // bytes per cacheline
  localparam int EDGE_SIZE               = 4;                            // bytes per edge
  localparam int CACHELINE_EDGE_NUM      = CACHELINE_SIZE / EDGE_SIZE;   // edges per line
  localparam int CACHELINE_EDGE_IDX_BITS = $clog2(CACHELINE_EDGE_NUM);

  typedef enum logic [1:0] {
    UNP_IDLE  = 2'd0,
    UNP_EMIT  = 2'd1,
    UNP_DRAIN = 2'd2
  } unpacker_state_e;

endpackage

// File: rtl/edge_cacheline_unpacker.sv
// Unpacks one cacheline read response into a stream of 32-bit edges, one per cycle.
// Latency: first edge_valid the cycle after line acceptance; line_ready returns 2 cycles after the last edge.
// Backpressure: edge_ready low holds edge_valid/edge_data/edge_last; lines are only accepted in IDLE.
// Ports: clock, rstn (async active-low); line_valid/line_ready/line_data/line_start/line_count/line_final
//        (line input); edge_valid/edge_ready/edge_data/edge_last (edge output); clamp_err (sticky),
//        edges_emitted (wrapping handshake count).
module edge_cacheline_unpacker
  import GLOBALS_CU_PKG::*;
#(
  parameter int LINE_BYTES = CACHELINE_SIZE,
  parameter int ELEM_BYTES = EDGE_SIZE,
  parameter int ELEMS      = LINE_BYTES / ELEM_BYTES,
  parameter int IDX_BITS   = $clog2(ELEMS),
  parameter int EW         = ELEM_BYTES * 8
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    line_valid,
  output logic                    line_ready,
  input  logic [0:LINE_BYTES*8-1] line_data,
  input  logic [IDX_BITS-1:0]     line_start,
  input  logic [IDX_BITS:0]       line_count,
  input  logic                    line_final,
  output logic                    edge_valid,
  input  logic                    edge_ready,
  output logic [EW-1:0]           edge_data,
  output logic                    edge_last,
  output logic                    clamp_err,
  output logic [31:0]             edges_emitted
);

  localparam int CW = IDX_BITS + 1;  // width able to hold 0..ELEMS

  unpacker_state_e        state_q, state_d;
  logic [0:LINE_BYTES*8-1] line_q, line_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [CW-1:0]          rem_q, rem_d;
  logic                   final_q, final_d;
  logic                   clamp_q, clamp_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   en_q;  // keeps line_ready low until the first clock out of reset

  logic [CW:0]   span;
  logic          over;
  logic [CW-1:0] eff_count;
  logic          accept;
  logic          hs;

  // A line extending past the last edge slot is truncated at the line end.
  assign span      = {2'b00, line_start} + {1'b0, line_count};
  assign over      = span > (CW+1)'(ELEMS);
  assign eff_count = over ? (CW'(ELEMS) - {1'b0, line_start}) : line_count;

  assign line_ready    = (state_q == UNP_IDLE) && en_q;
  assign accept        = line_valid && line_ready;
  assign edge_valid    = (state_q == UNP_EMIT);
  assign hs            = edge_valid && edge_ready;
  assign edge_data     = edge_valid ? line_q[idx_q*EW +: EW] : '0;
  assign edge_last     = edge_valid && final_q && (rem_q == CW'(1));
  assign clamp_err     = clamp_q;
  assign edges_emitted = cnt_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    final_d = final_q;
    clamp_d = clamp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNP_IDLE: begin
        // Zero-count lines are consumed without producing edges.
        if (accept && (line_count != '0)) begin
          line_d  = line_data;
          idx_d   = line_start;
          rem_d   = eff_count;
          final_d = line_final;
          state_d = UNP_EMIT;
          if (over) clamp_d = 1'b1;
        end
      end
      UNP_EMIT: begin
        if (hs) begin
          cnt_d = cnt_q + 32'd1;
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = UNP_DRAIN;  // idx stays put so it never steps past the line end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      UNP_DRAIN: state_d = UNP_IDLE;
      default:   state_d = UNP_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= UNP_IDLE;
      line_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      final_q <= 1'b0;
      clamp_q <= 1'b0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      final_q <= final_d;
      clamp_q <= clamp_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_cacheline_unpacker.sv
// Directed bench for edge_cacheline_unpacker: full line, tail line, clamped line,
// zero-count drop, consumer stall and reset in the middle of a line.
// Inputs change and outputs are sampled 1 time unit after each rising clock.
module tb_edge_cacheline_unpacker;

  logic          clock = 1'b0;
  logic          rstn;
  logic          line_valid;
  logic          line_ready;
  logic [0:1023] line_data;
  logic [4:0]    line_start;
  logic [5:0]    line_count;
  logic          line_final;
  logic          edge_valid;
  logic          edge_ready;
  logic [31:0]   edge_data;
  logic          edge_last;
  logic          clamp_err;
  logic [31:0]   edges_emitted;

  int total = 0;
  int bad   = 0;

  edge_cacheline_unpacker dut (
    .clock        (clock),
    .rstn         (rstn),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_data    (line_data),
    .line_start   (line_start),
    .line_count   (line_count),
    .line_final   (line_final),
    .edge_valid   (edge_valid),
    .edge_ready   (edge_ready),
    .edge_data    (edge_data),
    .edge_last    (edge_last),
    .clamp_err    (clamp_err),
    .edges_emitted(edges_emitted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] edge_val(input int i);
    return 32'hE000_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int start, input int count, input logic fin);
    line_valid = 1'b1;
    line_start = 5'(start);
    line_count = 6'(count);
    line_final = fin;
    tick();
    line_valid = 1'b0;
  endtask

  // Consume n edges with edge_ready high, then check the DRAIN gap and ready return.
  task automatic run_line(input string tag, input int start, input int n, input logic fin);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_vld"}, 32'(edge_valid), 32'd1);
      chk({tag, "_dat"}, edge_data, edge_val(start + k));
      chk({tag, "_last"}, 32'(edge_last), 32'((k == n - 1) && fin));
      chk({tag, "_lrdy_busy"}, 32'(line_ready), 32'd0);
      tick();
    end
    chk({tag, "_drain_vld"}, 32'(edge_valid), 32'd0);
    chk({tag, "_drain_lrdy"}, 32'(line_ready), 32'd0);
    tick();
    chk({tag, "_lrdy_back"}, 32'(line_ready), 32'd1);
  endtask

  logic rdy_pat [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int   dat_pat [6]  = '{5, 6, 6, 6, 7, 8};
  logic last_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rstn       = 1'b0;
    line_valid = 1'b0;
    line_start = '0;
    line_count = '0;
    line_final = 1'b0;
    edge_ready = 1'b1;
    for (int i = 0; i < 32; i++) line_data[i*32 +: 32] = edge_val(i);

    // Reset state
    tick();
    chk("rst_lrdy", 32'(line_ready), 32'd0);
    chk("rst_vld", 32'(edge_valid), 32'd0);
    chk("rst_dat", edge_data, 32'd0);
    chk("rst_last", 32'(edge_last), 32'd0);
    chk("rst_clamp", 32'(clamp_err), 32'd0);
    chk("rst_cnt", edges_emitted, 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_lrdy", 32'(line_ready), 32'd1);

    // Full line, 32 edges back to back
    send(0, 32, 1'b1);
    run_line("full", 0, 32, 1'b1);
    chk("full_cnt", edges_emitted, 32'd32);

    // Tail of a line, exactly reaching the end: no clamp
    send(28, 4, 1'b0);
    run_line("tail", 28, 4, 1'b0);
    chk("tail_clamp", 32'(clamp_err), 32'd0);
    chk("tail_cnt", edges_emitted, 32'd36);

    // Overrunning line: truncated to two edges, clamp_err sets
    send(30, 5, 1'b1);
    run_line("clamp", 30, 2, 1'b1);
    chk("clamp_err", 32'(clamp_err), 32'd1);
    chk("clamp_cnt", edges_emitted, 32'd38);

    // Zero-count line is dropped
    send(7, 0, 1'b1);
    chk("zero_vld", 32'(edge_valid), 32'd0);
    chk("zero_lrdy", 32'(line_ready), 32'd1);
    tick();
    chk("zero_vld2", 32'(edge_valid), 32'd0);
    chk("zero_cnt", edges_emitted, 32'd38);

    // Consumer stall: outputs hold, no duplicates or skips
    send(5, 4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      edge_ready = rdy_pat[k];
      chk("stall_vld", 32'(edge_valid), 32'd1);
      chk("stall_dat", edge_data, edge_val(dat_pat[k]));
      chk("stall_last", 32'(edge_last), 32'(last_pat[k]));
      tick();
    end
    edge_ready = 1'b1;
    chk("stall_drain_vld", 32'(edge_valid), 32'd0);
    chk("stall_cnt", edges_emitted, 32'd42);
    chk("stall_clamp_sticky", 32'(clamp_err), 32'd1);
    tick();
    chk("stall_lrdy", 32'(line_ready), 32'd1);

    // Reset in the middle of a line
    send(0, 32, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    chk("mid_dat10", edge_data, edge_val(10));
    chk("mid_cnt10", edges_emitted, 32'd52);
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(edge_valid), 32'd0);
    chk("mid_rst_cnt", edges_emitted, 32'd0);
    chk("mid_rst_clamp", 32'(clamp_err), 32'd0);
    chk("mid_rst_lrdy", 32'(line_ready), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_post_vld", 32'(edge_valid), 32'd0);
    send(3, 2, 1'b1);
    run_line("after_rst", 3, 2, 1'b1);
    chk("after_rst_cnt", edges_emitted, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
